countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
Sequencing controller for the WIDTH-bit synchronous down counter used by the timing datapath.
- Owns the count register and a clock prescaler.
- Host side gets load/start/stop controls, plus busy status and a one-cycle done pulse on terminal count.
- Count never wraps below zero.
- Sits between the top-level control FSM and any block that needs a programmable delay.

Parameters:
WIDTH, 4, bit width of count and load_val
PRESCALE, 1, clock cycles per decrement tick (>=1); 1 means decrement every cycle in RUN

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous active-low reset
load  input  1  capture load_val into count and reload register
load_val  input  WIDTH  value to load
start  input  1  begin or resume counting
stop  input  1  pause counting
count  output  WIDTH  current count value (registered)
busy  output  1  high while state is RUN
done  output  1  registered pulse, high exactly one cycle when count reaches 0

Behaviour:
- Reset (rst=0, async): count=0, reload=0, prescale counter=0, busy=0, done=0, state=IDLE. Effective immediately, including mid-RUN.
- All outputs are registered. busy is 1 iff state==RUN.
- States: IDLE, ARMED, RUN, PAUSE, DONE.
- IDLE:
  - load -> count<=load_val, reload<=load_val, go to ARMED.
  - start and stop are ignored.
- ARMED:
  - load -> recapture count and reload, stay in ARMED. load beats start in the same cycle.
  - start with count!=0 -> RUN, prescale counter cleared.
  - start with count==0 -> DONE, done=1 on that edge.
- RUN:
  - Prescale counter increments each cycle. tick = (prescale counter == PRESCALE-1); the counter clears on tick.
  - On tick: count<=count-1.
  - If count==1 on tick: count<=0, go to DONE, done<=1 on the same edge.
  - stop -> PAUSE, prescale counter held, no decrement that cycle. stop beats tick and start.
  - load is ignored in RUN.
- PAUSE:
  - count and prescale counter hold.
  - start (without stop) -> RUN, resuming the prescale phase.
  - load -> ARMED with the new value, prescale counter cleared. load beats start.
- DONE (lasts exactly one cycle):
  - done=1, count=0.
  - Next edge: done<=0 and state -> IDLE. With the optional feature, see below.
  - Inputs are ignored in DONE.
- Timing, PRESCALE=1: start sampled on edge k (ARMED->RUN, count=N). Count is N-1 at k+1 and 0 at k+N, with done=1 for the cycle after k+N.
- General timing: terminal count arrives N*PRESCALE edges after the start edge.
- Arithmetic: unsigned WIDTH bits. Decrement happens only when count!=0, so 0->all-ones wrap never occurs.

Optional Feature:
Macro COUNTDOWN_CTRL_AUTO_RELOAD_EN.
- Defined, reload!=0: from DONE, the next edge sets count<=reload, state->RUN, prescale counter cleared, done<=0. This gives a periodic done pulse every reload*PRESCALE+1 cycles until stop.
- Defined, reload==0: DONE->IDLE.
- Defined, stop in DONE: DONE->PAUSE with count=0. A later start from that PAUSE goes to DONE.
- Not defined: DONE always -> IDLE; reload register may be optimised away.

Test Plan:
- PRESCALE=1, load 3, start -> count 3,2,1,0 on consecutive edges after start; done=1 for exactly one cycle with count=0; busy falls with done; state returns to IDLE, count holds 0.
- load 9, start, stop when count=5, hold stop 4 cycles -> count stays 5, busy=0; start -> 4,3,2,1,0 then done pulse.
- load 0, start -> done=1 on the next edge, count stays 0, busy never asserted; start in IDLE afterwards -> no change.
- Simultaneous events:
  - start+stop in RUN -> PAUSE, count unchanged.
  - load(7)+start in ARMED -> count=7, state ARMED, busy=0.
  - load(4) during RUN -> ignored, countdown unaffected.
- PRESCALE=3, load 2, start -> count decrements every 3 cycles (2 for 3 cycles, 1 for 3 cycles, then 0), done pulse once.
- Reset: drive rst=0 mid-RUN at count=5 between clock edges -> count=0, busy=0, done=0 immediately; after release, start is ignored until load.
- With COUNTDOWN_CTRL_AUTO_RELOAD_EN, PRESCALE=1, load 2, start -> count 2,1,0,2,1,0,... with done high every 3rd cycle; stop -> halts.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Programmable down-counter sequencer with prescaled ticks, host load/start/stop and a done pulse.
// Optional auto-reload from DONE is enabled by defining COUNTDOWN_CTRL_AUTO_RELOAD_EN.
module countdown_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    typedef enum logic [2:0] {IDLE, ARMED, RUN, PAUSE, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic [PW-1:0]    pre_reg, pre_next;
    logic             done_reg, done_next;
    logic             busy_reg;
    logic             tick;

    assign tick = (pre_reg == PRE_LAST);

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        pre_next    = pre_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    count_next  = load_val;
                    reload_next = load_val;
                    state_next  = ARMED;
                end
            end
            ARMED: begin
                if (load) begin
                    count_next  = load_val;
                    reload_next = load_val;
                end else if (start) begin
                    pre_next = '0;
                    if (count_reg != '0) begin
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = PAUSE;
                end else if (tick) begin
                    pre_next = '0;
                    // Terminal tick (or a zero count) lands at 0 rather than wrapping.
                    if (count_reg == CNT_ONE || count_reg == '0) begin
                        count_next = '0;
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        count_next = count_reg - CNT_ONE;
                    end
                end else begin
                    pre_next = pre_reg + PW'(1);
                end
            end
            PAUSE: begin
                if (load) begin
                    count_next  = load_val;
                    reload_next = load_val;
                    pre_next    = '0;
                    state_next  = ARMED;
                end else if (start && !stop) begin
                    // Prescale phase is kept so a resume continues the partial tick.
                    if (count_reg != '0) begin
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            DONE: begin
                count_next = '0;
                state_next = IDLE;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
                if (stop) begin
                    state_next = PAUSE;
                end else if (reload_reg != '0) begin
                    count_next = reload_reg;
                    pre_next   = '0;
                    state_next = RUN;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            pre_reg    <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            pre_reg    <= pre_next;
            done_reg   <= done_next;
            busy_reg   <= (state_next == RUN);
        end
    end

    assign count = count_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed table-driven bench for countdown_ctrl: PRESCALE=1 and PRESCALE=3 instances share stimulus.
`timescale 1ns/1ps
module tb_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] count1, count3;
    logic       busy1, busy3, done1, done3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       ld;
        logic [3:0] val;
        logic       st;
        logic       sp;
        logic [3:0] cnt;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl3[$];
    vec_t tbla[$];

    always #5 clk = ~clk;

    countdown_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .count(count1), .busy(busy1), .done(done1)
    );

    countdown_ctrl #(.WIDTH(4), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .count(count3), .busy(busy3), .done(done3)
    );

    function automatic vec_t mk(input logic ld, input int val, input logic st, input logic sp,
                                input int cnt, input logic bsy, input logic dn);
        vec_t v;
        v.ld = ld; v.val = 4'(val); v.st = st; v.sp = sp;
        v.cnt = 4'(cnt); v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_row(input string tag, input int idx, input vec_t v, input bit use3);
        @(negedge clk);
        load = v.ld; load_val = v.val; start = v.st; stop = v.sp;
        @(posedge clk);
        #1;
        if (use3) begin
            chk($sformatf("%s[%0d].count", tag, idx), int'(count3), int'(v.cnt));
            chk($sformatf("%s[%0d].busy", tag, idx), int'(busy3), int'(v.bsy));
            chk($sformatf("%s[%0d].done", tag, idx), int'(done3), int'(v.dn));
            $display("%s[%0d] ld=%0b val=%0d st=%0b sp=%0b -> count=%0d busy=%0b done=%0b",
                     tag, idx, v.ld, v.val, v.st, v.sp, count3, busy3, done3);
        end else begin
            chk($sformatf("%s[%0d].count", tag, idx), int'(count1), int'(v.cnt));
            chk($sformatf("%s[%0d].busy", tag, idx), int'(busy1), int'(v.bsy));
            chk($sformatf("%s[%0d].done", tag, idx), int'(done1), int'(v.dn));
            $display("%s[%0d] ld=%0b val=%0d st=%0b sp=%0b -> count=%0d busy=%0b done=%0b",
                     tag, idx, v.ld, v.val, v.st, v.sp, count1, busy1, done1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; load_val = 4'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Rows are macro-neutral: stop is held in DONE so both builds leave it without reloading.
        // load 3 and run to done
        tbl1.push_back(mk(1, 3, 0, 0, 3, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 0, 3, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbl1.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        // load 9, pause at 5 for four cycles, resume
        tbl1.push_back(mk(1, 9, 0, 0, 9, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 0, 9, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 8, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 7, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 6, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 5, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 1, 5, 0, 0));
        tbl1.push_back(mk(0, 0, 0, 1, 5, 0, 0));
        tbl1.push_back(mk(0, 0, 0, 1, 5, 0, 0));
        tbl1.push_back(mk(0, 0, 0, 1, 5, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 0, 5, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 4, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 3, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbl1.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        // load 0: immediate done, then start in IDLE is ignored
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 0, 0, 0, 1));
        tbl1.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 1, 0, 0, 0));
        // simultaneous events
        tbl1.push_back(mk(1, 5, 0, 0, 5, 0, 0));
        tbl1.push_back(mk(1, 7, 1, 0, 7, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 0, 7, 1, 0));
        tbl1.push_back(mk(1, 4, 0, 0, 6, 1, 0));
        tbl1.push_back(mk(0, 0, 1, 1, 6, 0, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 6, 0, 0));
        tbl1.push_back(mk(1, 2, 1, 0, 2, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 0, 2, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbl1.push_back(mk(0, 0, 0, 1, 0, 0, 0));

        // PRESCALE=3: 2 for three cycles, 1 for three, then done
        tbl3.push_back(mk(1, 2, 0, 0, 2, 0, 0));
        tbl3.push_back(mk(0, 0, 1, 0, 2, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbl3.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        // PRESCALE=3: pause after two phase cycles, resume keeps the phase
        tbl3.push_back(mk(1, 2, 0, 0, 2, 0, 0));
        tbl3.push_back(mk(0, 0, 1, 0, 2, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 1, 2, 0, 0));
        tbl3.push_back(mk(0, 0, 1, 0, 2, 1, 0));
        tbl3.push_back(mk(0, 0, 0, 0, 1, 1, 0));

        // auto-reload, PRESCALE=1
        tbla.push_back(mk(1, 2, 0, 0, 2, 0, 0));
        tbla.push_back(mk(0, 0, 1, 0, 2, 1, 0));
        tbla.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        tbla.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbla.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        tbla.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        tbla.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbla.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        tbla.push_back(mk(0, 0, 0, 1, 2, 0, 0));
        tbla.push_back(mk(0, 0, 0, 1, 2, 0, 0));
        tbla.push_back(mk(0, 0, 1, 0, 2, 1, 0));
        tbla.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        tbla.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbla.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        tbla.push_back(mk(0, 0, 1, 0, 0, 0, 1));
        tbla.push_back(mk(0, 0, 0, 1, 0, 0, 0));

        // reset state
        #12;
        chk("reset.count", int'(count1), 0);
        chk("reset.busy", int'(busy1), 0);
        chk("reset.done", int'(done1), 0);
        $display("reset: count=%0d busy=%0b done=%0b", count1, busy1, done1);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl1[i]) run_row("p1", i, tbl1[i], 1'b0);

        do_reset();
        foreach (tbl3[i]) run_row("p3", i, tbl3[i], 1'b1);

        // asynchronous reset mid-RUN at count 5, then start alone must not run
        do_reset();
        run_row("rst", 0, mk(1, 9, 0, 0, 9, 0, 0), 1'b0);
        run_row("rst", 1, mk(0, 0, 1, 0, 9, 1, 0), 1'b0);
        for (int k = 0; k < 4; k++) run_row("rst", 2 + k, mk(0, 0, 0, 0, 8 - k, 1, 0), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.count", int'(count1), 0);
        chk("async_rst.busy", int'(busy1), 0);
        chk("async_rst.done", int'(done1), 0);
        $display("async reset mid-run: count=%0d busy=%0b done=%0b", count1, busy1, done1);
        @(negedge clk);
        rst = 1'b1;
        run_row("rst", 6, mk(0, 0, 1, 0, 0, 0, 0), 1'b0);
        run_row("rst", 7, mk(0, 0, 1, 0, 0, 0, 0), 1'b0);
        run_row("rst", 8, mk(1, 3, 0, 0, 3, 0, 0), 1'b0);

`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
        do_reset();
        foreach (tbla[i]) run_row("ar", i, tbla[i], 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
